psum_drain: RTL and testbench
=============================

# psum_drain

Reads accumulated partial sums out of the PE psum scratchpad and streams them toward the global buffer over a valid/ready interface. It is the read-side counterpart of the accumulation path, where the adder writes psums into the scratchpad. The block sequences scratchpad reads, absorbs the scratchpad's 1-cycle read latency, and honours downstream backpressure without dropping or duplicating entries.

## Interface
Parameters:
- `width`, 6: psum width in bits, two's complement.
- `depth`, 24: psum scratchpad entries.
- `addr_w`, 5: scratchpad address width; must satisfy 2^addr_w >= depth.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic rises on this edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request to begin a drain; sampled only in IDLE.
- `num`  in  addr_w+1  entry count to drain, starting at address 0; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when a drain completes.
- `spad_re`  out  1  scratchpad read enable.
- `spad_raddr`  out  addr_w  scratchpad read address.
- `spad_rdata`  in  width  read data, valid the cycle after `spad_re`.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  width  psum value.
- `out_last`  out  1  marks the final beat of a drain.

## Operation
- FSM states:
  - IDLE: on `start`, go to READ. If `num`==0, go straight to DONE.
  - READ: issue reads until `num` reads have been issued, then go to FLUSH.
  - FLUSH: wait until the final beat handshakes, then go to DONE.
  - DONE: one cycle, then IDLE.
- Effective count is min(`num`, `depth`); out-of-range values are clamped.
- Reads are issued at addresses 0,1,2… in order. No wrap-around.
- Credit rule: a read issues only when outstanding reads plus buffered entries is less than 2. Returned data therefore always has a slot in the 2-entry output buffer.
- Handshake:
  - A beat transfers when `out_valid` and `out_ready` are both high.
  - While `out_valid` is high and `out_ready` is low, `out_data` and `out_last` hold stable.
  - `out_valid` never drops without a transfer.
- `out_last` is high only on the beat carrying the final address.
- `start` while `busy` is ignored. No queuing.
- Reset mid-drain: everything returns to reset values immediately, the buffer empties, and no `done` is produced. Scratchpad contents are not affected.
- Reset values: `busy`=0, `done`=0, `spad_re`=0, `spad_raddr`=0, `out_valid`=0, `out_data`=0, `out_last`=0. The FSM is in IDLE.

## Timing
- Cycle 0: `start` sampled.
- Cycle 1: `busy`=1, `spad_re`=1, `spad_raddr`=0.
- Cycle 2: `spad_rdata` valid; captured into the buffer at the end of the cycle.
- Cycle 3: first `out_valid`. Latency from `start` to first beat is 3 cycles.
- With `out_ready` held high: one beat per cycle, last beat in cycle 2+N, `done` in cycle 3+N, `busy` low in cycle 4+N.
- With `out_ready` low, at most 2 entries are buffered and `spad_re` stalls. Reads resume the cycle after a transfer frees a slot.
- `num`=0: `done` in cycle 1, with no reads and no beats.

## Configuration
- `PSUM_DRAIN_RELU_EN`:
  - Defined: `out_data` is forced to 0 when the psum sign bit is 1, i.e. ReLU applied on output. Positive values pass unchanged.
  - Undefined: `out_data` is the raw two's-complement psum.
- Beat count, timing and `out_last` are identical in both builds.

## Structure
- Shared package `pe_pkg` holds:
  - the drain FSM state enum (IDLE, READ, FLUSH, DONE);
  - the constants `PSUM_W`=6 and `PSUM_SPAD_DEPTH`=24.
- Sub-module `drain_fifo2`: 2-entry FIFO of {last, data}, with a push from the scratchpad return path and valid/ready on the pop side. It also provides the occupancy count used by the credit rule.

## Test plan
- Scratchpad holds values 0..23, `num`=24, `out_ready`=1 → 24 beats with data 0..23 in cycles 3..26, `out_last` only on 23, `done` in cycle 27.
- Same setup, `out_ready` toggling 1,0,1,0… → data 0..23 in order, no duplicates, `out_data` stable during every stalled cycle, at most 2 reads outstanding plus buffered.
- `num`=0 → `done` in cycle 1. `num`=31 → clamped, exactly 24 beats.
- Address 5 holds −3 (6'b111101): without the macro `out_data`=6'b111101; with `PSUM_DRAIN_RELU_EN` `out_data`=0; address 6 holding +7 outputs 7 in both builds.
- `start` pulsed again in cycle 5 of a drain → ignored, single `done`.
- `rst_n` asserted in cycle 8 with `out_ready`=0 → all outputs 0 immediately, no `done`. A new `start` after release drains from address 0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared PE definitions: psum geometry and the drain sequencer state encoding.
package pe_pkg;

    localparam int PSUM_W          = 6;
    localparam int PSUM_SPAD_DEPTH = 24;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        FLUSH,
        DONE
    } drain_state_t;

endpackage

// File: rtl/drain_fifo2.sv
// Two-entry {last, data} skid buffer between the scratchpad return path and the output stream.
module drain_fifo2
    import pe_pkg::*;
#(
    parameter int width = PSUM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [width-1:0] i_push_data,
    input  logic             i_push_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [width-1:0] o_data,
    output logic             o_last,
    output logic [1:0]       o_count
);

    logic [width-1:0] r_data [2];
    logic [1:0]       r_last;
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_cnt;
    logic             w_pop;

    assign w_pop = o_valid && i_ready;

    // Push is only ever issued when a slot is guaranteed free by the caller's credit check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_last    <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (i_push) begin
                r_data[r_wptr] <= i_push_data;
                r_last[r_wptr] <= i_push_last;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_data[r_rptr];
    assign o_last  = r_last[r_rptr];
    assign o_count = r_cnt;

endmodule

// File: rtl/psum_drain.sv
// Streams psums from the PE scratchpad to the global buffer with credit-limited reads.
// Define PSUM_DRAIN_RELU_EN to clamp negative psums to zero on the output.
module psum_drain
    import pe_pkg::*;
#(
    parameter int width  = PSUM_W,
    parameter int depth  = PSUM_SPAD_DEPTH,
    parameter int addr_w = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [addr_w:0]   num,
    output logic              busy,
    output logic              done,
    output logic              spad_re,
    output logic [addr_w-1:0] spad_raddr,
    input  logic [width-1:0]  spad_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [width-1:0]  out_data,
    output logic              out_last
);

    localparam logic [addr_w:0] DEPTH_C = (addr_w+1)'(depth);
    localparam logic [addr_w:0] ONE_C   = {{addr_w{1'b0}}, 1'b1};

    drain_state_t      r_state;
    drain_state_t      w_next;
    logic [addr_w:0]   r_count;
    logic [addr_w:0]   r_issued;
    logic              r_pend;
    logic              r_pend_last;
    logic [addr_w:0]   w_eff_num;
    logic [1:0]        w_fifo_count;
    logic [1:0]        w_used;
    logic              w_pop;
    logic              w_issue;
    logic              w_issue_last;
    logic [width-1:0]  w_push_data;

    assign w_eff_num = (num > DEPTH_C) ? DEPTH_C : num;
    assign w_pop     = out_valid && out_ready;

    // A slot freed by this cycle's pop counts, so a steady ready stream sustains one beat per cycle.
    assign w_used       = {1'b0, r_pend} + w_fifo_count - {1'b0, w_pop};
    assign w_issue      = (r_state == READ) && (w_used < 2'd2) && (r_issued < r_count);
    assign w_issue_last = w_issue && ((r_issued + ONE_C) == r_count);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (start) w_next = (w_eff_num == '0) ? DONE : READ;
            READ:  if (w_issue_last) w_next = FLUSH;
            FLUSH: if (w_pop && out_last) w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_issued    <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_pend      <= w_issue;
            r_pend_last <= w_issue_last;
            if (r_state == IDLE && start) begin
                r_count  <= w_eff_num;
                r_issued <= '0;
            end else if (w_issue) begin
                r_issued <= r_issued + ONE_C;
            end else if (r_state == DONE) begin
                r_issued <= '0;
            end
        end
    end

`ifdef PSUM_DRAIN_RELU_EN
    assign w_push_data = spad_rdata[width-1] ? '0 : spad_rdata;
`else
    assign w_push_data = spad_rdata;
`endif

    drain_fifo2 #(
        .width(width)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_pend),
        .i_push_data (w_push_data),
        .i_push_last (r_pend_last),
        .o_valid     (out_valid),
        .i_ready     (out_ready),
        .o_data      (out_data),
        .o_last      (out_last),
        .o_count     (w_fifo_count)
    );

    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign spad_re    = w_issue;
    assign spad_raddr = r_issued[addr_w-1:0];

endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain: scratchpad model, randomized backpressure, reference beat list.
module tb_psum_drain;

    localparam int W  = 6;
    localparam int D  = 24;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   num = '0;
    logic          busy;
    logic          done;
    logic          spad_re;
    logic [AW-1:0] spad_raddr;
    logic [W-1:0]  spad_rdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_last;

    psum_drain #(.width(W), .depth(D), .addr_w(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num        (num),
        .busy       (busy),
        .done       (done),
        .spad_re    (spad_re),
        .spad_raddr (spad_raddr),
        .spad_rdata (spad_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scratchpad model with one cycle of read latency.
    logic [W-1:0] mem [D];
    always @(posedge clk) begin
        if (spad_re && spad_raddr < AW'(D)) spad_rdata <= mem[spad_raddr];
    end

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t        expQ[$];
    logic [W-1:0] beatData[$];
    int nCompared = 0;
    int nMismatched = 0;
    int startCyc = 0;
    int readyMode = 0;
    int doneCount = 0;
    int doneBase = 0;
    int doneRel = -1;
    int firstBeatRel = -1;
    int lastBeatRel = -1;
    int beatCount = 0;
    int readCount = 0;
    int expAddr = 0;

    function automatic logic [W-1:0] refOut(input logic [W-1:0] v);
`ifdef PSUM_DRAIN_RELU_EN
        return ($signed(v) < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_spad_re"}, spad_re, 0);
        checkOutput({tag, "_spad_raddr"}, spad_raddr, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_data"}, out_data, 0);
        checkOutput({tag, "_out_last"}, out_last, 0);
    endtask

    // Downstream ready pattern: 0 always, 1 toggling, 2 random, 3 never.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks protocol rules.
    initial begin : monitor
        int    rel;
        beat_t e;
        logic  prevStall;
        logic [W-1:0] prevData;
        logic  prevLast;
        prevStall = 1'b0;
        prevData  = '0;
        prevLast  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevStall = 1'b0;
            end else begin
                rel = cyc - startCyc;
                if (spad_re) begin
                    checkOutput("read_addr", 32'(spad_raddr), expAddr);
                    expAddr++;
                    readCount++;
                end
                if (prevStall)
                    checkOutput("stall_hold", {out_valid, out_last, out_data}, {1'b1, prevLast, prevData});
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        nCompared++;
                        nMismatched++;
                        $display("[TB] FAIL unexpected_beat: got data %0d with no beat expected", out_data);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("beat_data", out_data, e.data);
                        checkOutput("beat_last", out_last, e.last);
                    end
                    if (beatCount == 0) firstBeatRel = rel;
                    lastBeatRel = rel;
                    beatCount++;
                    beatData.push_back(out_data);
                end
                checkOutput("credit_limit", 32'((readCount - beatCount) <= 2), 1);
                if (done) begin
                    doneCount++;
                    doneRel = rel;
                    checkOutput("done_drained", expQ.size(), 0);
                end
                prevStall = out_valid && !out_ready;
                prevData  = out_data;
                prevLast  = out_last;
            end
        end
    end

    task automatic applyStimulus(input int n, input bit pushExp);
        int effN;
        effN = (n > D) ? D : n;
        if (pushExp) begin
            for (int i = 0; i < effN; i++) begin
                beat_t b;
                b.data = refOut(mem[i]);
                b.last = (i == effN - 1);
                expQ.push_back(b);
            end
        end
        expAddr      = 0;
        readCount    = 0;
        beatCount    = 0;
        firstBeatRel = -1;
        lastBeatRel  = -1;
        doneRel      = -1;
        beatData.delete();
        doneBase     = doneCount;
        @(posedge clk);
        #1;
        start    = 1'b1;
        num      = (AW+1)'(n);
        startCyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        num   = (AW+1)'($urandom);
    endtask

    task automatic waitDone(input int budget, input int reStartAt);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #2;
            start = (reStartAt > 0 && (cyc - startCyc) == reStartAt);
            if (doneCount != doneBase) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!ok) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL done_timeout: no done within %0d cycles", budget);
        end else begin
            checkOutput("busy_after_done", busy, 0);
        end
    endtask

    initial begin
        int n;
        int base;
        for (int i = 0; i < D; i++) mem[i] = W'(i);

        rst_n = 1'b0;
        #1;
        checkResetOutputs("por");
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;

        $display("[TB] full-rate drain of 24 entries");
        readyMode = 0;
        @(posedge clk);
        applyStimulus(24, 1'b1);
        waitDone(200, 0);
        checkOutput("first_beat_cycle", firstBeatRel, 3);
        checkOutput("last_beat_cycle", lastBeatRel, 26);
        checkOutput("done_cycle", doneRel, 27);
        checkOutput("beats_24", beatCount, 24);

        $display("[TB] toggling backpressure");
        readyMode = 1;
        applyStimulus(24, 1'b1);
        waitDone(300, 0);
        checkOutput("toggle_beats", beatCount, 24);

        $display("[TB] zero-length drain");
        readyMode = 0;
        applyStimulus(0, 1'b1);
        waitDone(20, 0);
        checkOutput("num0_done_cycle", doneRel, 1);
        checkOutput("num0_reads", readCount, 0);
        checkOutput("num0_beats", beatCount, 0);

        $display("[TB] clamped drain num=31");
        readyMode = 2;
        applyStimulus(31, 1'b1);
        waitDone(500, 0);
        checkOutput("clamp_beats", beatCount, 24);
        checkOutput("clamp_reads", readCount, 24);

        $display("[TB] sign handling at addresses 5 and 6");
        mem[5] = 6'b111101;
        mem[6] = 6'd7;
        readyMode = 0;
        applyStimulus(8, 1'b1);
        waitDone(100, 0);
        checkOutput("sign_beats", beatData.size(), 8);
        if (beatData.size() == 8) begin
`ifdef PSUM_DRAIN_RELU_EN
            checkOutput("neg_psum_out", beatData[5], 0);
`else
            checkOutput("neg_psum_out", beatData[5], 6'b111101);
`endif
            checkOutput("pos_psum_out", beatData[6], 7);
        end
        mem[5] = 6'd5;
        mem[6] = 6'd6;

        $display("[TB] start repeated while busy");
        readyMode = 0;
        applyStimulus(24, 1'b1);
        base = doneBase;
        waitDone(200, 5);
        repeat (10) @(posedge clk);
        #2;
        checkOutput("single_done", doneCount - base, 1);
        checkOutput("restart_beats", beatCount, 24);
        checkOutput("restart_idle", busy, 0);

        $display("[TB] reset in the middle of a stalled drain");
        readyMode = 3;
        applyStimulus(24, 1'b0);
        base = doneCount;
        repeat (7) @(posedge clk);
        #1;
        checkOutput("stalled_reads", readCount, 2);
        checkOutput("stalled_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("mid_reset");
        expQ.delete();
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("no_done_after_reset", doneCount, base);
        readyMode = 2;
        applyStimulus(10, 1'b1);
        waitDone(300, 0);
        checkOutput("post_reset_beats", beatCount, 10);

        $display("[TB] randomized drains");
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < D; i++) mem[i] = W'($urandom);
            n = $urandom_range(1, 31);
            readyMode = 2;
            applyStimulus(n, 1'b1);
            waitDone(600, 0);
            checkOutput("rand_beats", beatCount, (n > D) ? D : n);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
